// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module     : mem_access_unit
// Description: Memory-side stage behind the multicycle control FSM. Converts
//              per-state read/write strobes into a single valid/ready bus
//              transaction, stalls the core while it is outstanding, returns
//              sign/zero-extended load data, and flags misaligned requests
//              and bus timeouts.
// Ports      : clk, reset (sync, active-high)
//              rd_req, wr_strb, funct3, addr, wdata   - request from core FSM
//              rdata, done, stall, misalign_err, bus_err - status to core
//              bus_valid/bus_ready/bus_we/bus_addr/bus_wdata/bus_wstrb
//              bus_rvalid/bus_rdata                    - memory bus
// Revision   : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [3:0]        wr_strb,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              stall,
  output logic              misalign_err,
  output logic              bus_err,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_RESP = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam int              CNT_W       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        lane_q, lane_d;
  logic [2:0]        f3_q, f3_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_bus_q, err_bus_d;

  logic              w_wr_req;
  logic              w_req;
  logic              w_misalign;
  logic              w_complete;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [31:0]       w_wdata_shifted;

  // Select byte/halfword lane out of the raw word and extend by funct3.
  // Unlisted encodings fall through to a raw word.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  extend_load = {{24{b[7]}}, b};
      3'b001:  extend_load = {{16{h[15]}}, h};
      3'b100:  extend_load = {24'b0, b};
      3'b101:  extend_load = {16'b0, h};
      default: extend_load = word;
    endcase
  endfunction

  assign w_wr_req        = |wr_strb;
  assign w_req           = w_wr_req | rd_req;
  assign w_cnt_inc       = cnt_q + CNT_W'(1);
  assign w_wdata_shifted = wdata << {addr[1:0], 3'b000};

  always_comb begin
    w_misalign = 1'b0;
    case (funct3)
      3'b000, 3'b100: w_misalign = 1'b0;
      3'b001, 3'b101: w_misalign = addr[0];
      default:        w_misalign = (addr[1:0] != 2'b00);
    endcase
  end

  // A write finishes on the ready handshake; a read finishes when data
  // arrives, which may coincide with the handshake.
  assign w_complete = ((state_q == S_REQ) && bus_ready && (we_q || bus_rvalid)) ||
                      ((state_q == S_RESP) && bus_rvalid);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    lane_d    = lane_q;
    f3_d      = f3_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_bus_d = err_bus_q;
    case (state_q)
      S_IDLE: begin
        if (w_req) begin
          if (w_misalign) begin
            state_d   = S_ERR;
            err_bus_d = 1'b0;
          end else begin
            state_d = S_REQ;
            cnt_d   = '0;
            addr_d  = {addr[ADDR_W-1:2], 2'b00};
            lane_d  = addr[1:0];
            f3_d    = funct3;
            // Write wins when both strobes are present.
            we_d    = w_wr_req;
            wdata_d = w_wr_req ? w_wdata_shifted : 32'b0;
            wstrb_d = wr_strb;
          end
        end
      end
      S_REQ, S_RESP: begin
        cnt_d = w_cnt_inc;
        if (w_complete) begin
          state_d = S_DONE;
          if (!we_q) begin
            rdata_d = extend_load(bus_rdata, lane_q, f3_q);
          end
        end else if (w_cnt_inc >= TIMEOUT_VAL) begin
          state_d   = S_ERR;
          err_bus_d = 1'b1;
        end else if ((state_q == S_REQ) && bus_ready) begin
          state_d = S_RESP;
        end
      end
      S_DONE, S_ERR: state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      lane_q    <= '0;
      f3_q      <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_bus_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      lane_q    <= lane_d;
      f3_q      <= f3_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      err_bus_q <= err_bus_d;
    end
  end

  assign rdata        = rdata_q;
  assign done         = (state_q == S_DONE);
  assign misalign_err = (state_q == S_ERR) && !err_bus_q;
  assign bus_err      = (state_q == S_ERR) && err_bus_q;
  // Stall rises combinationally on the request cycle so the core freezes
  // before the registered state catches up.
  assign stall        = ((state_q == S_IDLE) && w_req) ||
                        (state_q == S_REQ) || (state_q == S_RESP);
  assign bus_valid    = (state_q == S_REQ);
  assign bus_we       = we_q;
  assign bus_addr     = addr_q;
  assign bus_wdata    = wdata_q;
  assign bus_wstrb    = wstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module     : tb_mem_access_unit
// Description: Self-checking bench for mem_access_unit. Each transaction is
//              predicted from a cycle-count model of the bus protocol and a
//              plain-arithmetic load-extension model.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_req;
  logic [3:0]  wr_strb;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done, stall, misalign_err, bus_err;
  logic        bus_valid, bus_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_rdata = 32'b0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .wr_strb(wr_strb),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .done(done), .stall(stall), .misalign_err(misalign_err), .bus_err(bus_err),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  function automatic int size_of(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input int lane,
                                           input logic [2:0] f3);
    int unsigned b, h;
    b = (word >> (8 * lane)) & 32'hFF;
    h = (word >> (16 * (lane / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? (b + 32'hFFFFFF00) : b;
      3'b001:  return (h >= 32768) ? (h + 32'hFFFF0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return word;
    endcase
  endfunction

  task automatic drive_idle();
    rd_req = 1'b0; wr_strb = 4'b0; funct3 = 3'b0; addr = 32'b0; wdata = 32'b0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'b0;
  endtask

  // One transaction: w = cycles with ready low before the handshake,
  // v = cycles from handshake to read data (0 = same cycle).
  task automatic do_txn(input bit is_wr, input bit also_rd, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [3:0] strb,
                        input logic [31:0] word, input int w, input int v, input string name);
    int n, e;
    bit mis, ok, exp_valid;
    logic [31:0] exp_wd, exp_addr;
    mis      = (a % size_of(f3)) != 0;
    n        = is_wr ? (w + 1) : (w + 1 + v);
    ok       = !mis && (n <= TO);
    e        = mis ? 1 : (ok ? n + 1 : TO + 1);
    exp_wd   = wd << (8 * (a % 4));
    exp_addr = a - (a % 4);

    @(posedge clk); #1;
    checks++;
    if (stall !== 1'b0 || done !== 1'b0 || bus_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: stall=%b done=%b valid=%b required 0 0 0", name, stall, done, bus_valid);
    end
    rd_req = also_rd | !is_wr; wr_strb = is_wr ? strb : 4'b0;
    funct3 = f3; addr = a; wdata = wd;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL %s req_stall: got %b required 1", name, stall);
    end

    for (int k = 1; k <= e; k++) begin
      @(posedge clk); #1;
      if (k < e) begin
        exp_valid = (k <= w + 1);
        checks++;
        if (stall !== 1'b1 || done !== 1'b0 || bus_err !== 1'b0 || misalign_err !== 1'b0 ||
            bus_valid !== exp_valid) begin
          errors++;
          $display("FAIL %s busy k=%0d: stall=%b done=%b berr=%b merr=%b valid=%b required 1 0 0 0 %b",
                   name, k, stall, done, bus_err, misalign_err, bus_valid, exp_valid);
        end
        if (exp_valid) begin
          checks++;
          if (bus_addr !== exp_addr || bus_we !== is_wr ||
              bus_wstrb !== (is_wr ? strb : 4'b0) || (is_wr && bus_wdata !== exp_wd)) begin
            errors++;
            $display("FAIL %s bus k=%0d: addr=%h we=%b strb=%b wdata=%h required %h %b %b %h",
                     name, k, bus_addr, bus_we, bus_wstrb, bus_wdata, exp_addr, is_wr,
                     is_wr ? strb : 4'b0, exp_wd);
          end
        end
        // Inputs wander while stalled; only the latched copy may matter.
        rd_req = $urandom_range(0, 1); wr_strb = 4'($urandom); funct3 = 3'($urandom);
        addr = $urandom; wdata = $urandom;
        bus_ready  = (k == w + 1);
        bus_rvalid = !is_wr && (k == w + 1 + v);
        bus_rdata  = bus_rvalid ? word : $urandom;
      end else begin
        checks++;
        if (done !== ok || bus_err !== (!mis && !ok) || misalign_err !== mis ||
            stall !== 1'b0 || bus_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s end k=%0d: done=%b berr=%b merr=%b stall=%b valid=%b required %b %b %b 0 0",
                   name, k, done, bus_err, misalign_err, stall, bus_valid, ok, !mis && !ok, mis);
        end
        if (ok && !is_wr) model_rdata = ref_load(word, int'(a % 4), f3);
        if (!is_wr || !ok) begin
          checks++;
          if (rdata !== model_rdata) begin
            errors++;
            $display("FAIL %s rdata: got %h required %h", name, rdata, model_rdata);
          end
        end
        drive_idle();
      end
    end
  endtask

  function automatic logic [31:0] pick_addr(input logic [2:0] f3, input bit allow_mis);
    logic [31:0] base;
    int sz;
    base = $urandom & 32'hFFFF_FFFC;
    sz   = size_of(f3);
    if (allow_mis && $urandom_range(0, 3) == 0) return base | $urandom_range(0, 3);
    if (sz == 1) return base | $urandom_range(0, 3);
    if (sz == 2) return base | (2 * $urandom_range(0, 1));
    return base;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rdata !== 32'b0 || done !== 1'b0 || stall !== 1'b0 || misalign_err !== 1'b0 ||
        bus_err !== 1'b0 || bus_valid !== 1'b0 || bus_we !== 1'b0 ||
        bus_addr !== 32'b0 || bus_wdata !== 32'b0 || bus_wstrb !== 4'b0) begin
      errors++;
      $display("FAIL reset: rdata=%h done=%b stall=%b merr=%b berr=%b valid=%b we=%b addr=%h wd=%h strb=%b required all 0",
               rdata, done, stall, misalign_err, bus_err, bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb);
    end
    reset = 1'b0;
    model_rdata = 32'b0;
  endtask

  task automatic test_directed();
    do_txn(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 4'b0, 32'hDEADBEEF, 0, 1, "lw_lat3");
    checks++;
    if (rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lw_value: got %h required deadbeef", rdata);
    end
    do_txn(1'b0, 1'b0, 3'b000, 32'h103, 32'h0, 4'b0, 32'h80112233, 0, 0, "lb");
    checks++;
    if (rdata !== 32'hFFFFFF80) begin
      errors++; $display("FAIL lb_value: got %h required ffffff80", rdata);
    end
    do_txn(1'b0, 1'b0, 3'b100, 32'h103, 32'h0, 4'b0, 32'h80112233, 0, 0, "lbu");
    checks++;
    if (rdata !== 32'h00000080) begin
      errors++; $display("FAIL lbu_value: got %h required 00000080", rdata);
    end
    do_txn(1'b0, 1'b0, 3'b001, 32'h202, 32'h0, 4'b0, 32'h9234_5678, 1, 2, "lh_hi");
    do_txn(1'b0, 1'b0, 3'b101, 32'h202, 32'h0, 4'b0, 32'h9234_5678, 0, 0, "lhu_hi");
    do_txn(1'b1, 1'b0, 3'b001, 32'h202, 32'h0000ABCD, 4'b1100, 32'h0, 0, 0, "sh");
    do_txn(1'b1, 1'b1, 3'b010, 32'h400, 32'h1234_5678, 4'b1111, 32'h0, 2, 0, "sw_wins");
    do_txn(1'b0, 1'b0, 3'b010, 32'h101, 32'h0, 4'b0, 32'h0, 0, 0, "lw_misalign");
    do_txn(1'b1, 1'b0, 3'b001, 32'h203, 32'h55, 4'b0011, 32'h0, 0, 0, "sh_misalign");
    do_txn(1'b0, 1'b0, 3'b010, 32'h300, 32'h0, 4'b0, 32'h0, 100, 0, "timeout_ready");
    do_txn(1'b0, 1'b0, 3'b010, 32'h304, 32'h0, 4'b0, 32'h0, 0, 100, "timeout_rvalid");
    do_txn(1'b0, 1'b0, 3'b010, 32'h308, 32'h0, 4'b0, 32'hCAFE_F00D, 1, 2, "edge_complete");
  endtask

  task automatic test_random();
    logic [2:0] rd_f3s [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    for (int i = 0; i < 150; i++) begin
      bit          is_wr;
      logic [2:0]  f3;
      logic [31:0] a;
      is_wr = ($urandom_range(0, 2) == 0);
      f3    = is_wr ? 3'($urandom_range(0, 2)) : rd_f3s[$urandom_range(0, 7)];
      a     = pick_addr(f3, 1'b1);
      do_txn(is_wr, 1'($urandom_range(0, 1)), f3, a, $urandom,
             4'($urandom_range(1, 15)), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      logic [2:0] f3;
      f3 = 3'($urandom_range(0, 5));
      if (f3 == 3'b011) f3 = 3'b010;
      do_txn(1'b0, 1'b0, f3, pick_addr(f3, 1'b0), 32'h0, 4'b0, $urandom, 0, 0, "b2b");
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    rd_req = 1'b1; funct3 = 3'b010; addr = 32'h40;
    @(posedge clk); #1;
    checks++;
    if (bus_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_req: valid=%b required 1", bus_valid);
    end
    rd_req = 1'b0; bus_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus_valid !== 1'b0 || stall !== 1'b1) begin
      errors++; $display("FAIL rstmid_resp: valid=%b stall=%b required 0 1", bus_valid, stall);
    end
    reset = 1'b1; bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = $urandom;
    @(posedge clk); #1;
    checks++;
    if (stall !== 1'b0 || done !== 1'b0 || bus_valid !== 1'b0 || rdata !== 32'b0) begin
      errors++;
      $display("FAIL rstmid_after: stall=%b done=%b valid=%b rdata=%h required 0 0 0 0",
               stall, done, bus_valid, rdata);
    end
    reset = 1'b0; bus_rvalid = 1'b0;
    model_rdata = 32'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || stall !== 1'b0 || bus_err !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle: done=%b stall=%b berr=%b required 0 0 0", done, stall, bus_err);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    do_txn(1'b0, 1'b0, 3'b000, 32'h501, 32'h0, 4'b0, 32'h00FF_7F00, 0, 1, "post_reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
